// File: rtl/uart_rx_deframer.sv
// UART receiver that gathers NUM_WORDS start/data/stop packets into one wide beat
// and presents it on a one-deep valid/ready output register.
module uart_rx_deframer #(
  parameter int CLOCKS_PER_PULSE = 4,
  parameter int BITS_PER_WORD    = 8,
  parameter int PACKET_SIZE      = 13,
  parameter int W_OUT            = 24
) (
  input  logic                                         clk,
  input  logic                                         rstn,
  input  logic                                         rx,
  output logic [W_OUT/BITS_PER_WORD-1:0][BITS_PER_WORD-1:0] m_data,
  output logic                                         m_valid,
  input  logic                                         m_ready,
  output logic                                         frame_err,
  output logic                                         overrun
);

  localparam int END_BITS  = PACKET_SIZE - BITS_PER_WORD - 1;
  localparam int NUM_WORDS = W_OUT / BITS_PER_WORD;
  localparam int CW        = (CLOCKS_PER_PULSE > 2) ? $clog2(CLOCKS_PER_PULSE) : 1;
  localparam int BW        = $clog2(PACKET_SIZE);
  localparam int WW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, RESYNC, DELIVER} state_t;
  typedef logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0] beat_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] c_clocks_reg, c_clocks_next;
  logic [BW-1:0] c_bits_reg, c_bits_next;
  logic [WW-1:0] c_words_reg, c_words_next;
  beat_t         asm_reg, asm_next;
  beat_t         out_reg, out_next;
  logic          valid_reg, valid_next;
  logic          frame_err_reg, frame_err_next;
  logic          overrun_reg, overrun_next;
  logic          rx_meta_reg, rx_s_reg;
  logic          bit_tick;

  assign m_data    = out_reg;
  assign m_valid   = valid_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;
  assign bit_tick  = (c_clocks_reg == CW'(CLOCKS_PER_PULSE - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      c_clocks_reg  <= '0;
      c_bits_reg    <= '0;
      c_words_reg   <= '0;
      asm_reg       <= '0;
      out_reg       <= '0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      rx_meta_reg   <= 1'b1;
      rx_s_reg      <= 1'b1;
    end else begin
      state_reg     <= state_next;
      c_clocks_reg  <= c_clocks_next;
      c_bits_reg    <= c_bits_next;
      c_words_reg   <= c_words_next;
      asm_reg       <= asm_next;
      out_reg       <= out_next;
      valid_reg     <= valid_next;
      frame_err_reg <= frame_err_next;
      overrun_reg   <= overrun_next;
      rx_meta_reg   <= rx;
      rx_s_reg      <= rx_meta_reg;
    end
  end

  always_comb begin
    state_next     = state_reg;
    c_clocks_next  = c_clocks_reg;
    c_bits_next    = c_bits_reg;
    c_words_next   = c_words_reg;
    asm_next       = asm_reg;
    out_next       = out_reg;
    valid_next     = valid_reg;
    frame_err_next = 1'b0;
    overrun_next   = 1'b0;

    // A handshake frees the output register; DELIVER below may refill it in the same cycle.
    if (valid_reg && m_ready) valid_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!rx_s_reg) begin
          state_next    = START;
          c_clocks_next = '0;
        end
      end
      START: begin
        if (c_clocks_reg == CW'(CLOCKS_PER_PULSE / 2 - 1)) begin
          c_clocks_next = '0;
          c_bits_next   = '0;
          state_next    = rx_s_reg ? IDLE : DATA;
        end else begin
          c_clocks_next = c_clocks_reg + 1'b1;
        end
      end
      DATA: begin
        if (bit_tick) begin
          c_clocks_next = '0;
          for (int i = 0; i < NUM_WORDS; i++) begin
            if (c_words_reg == WW'(i))
              asm_next[i] = {rx_s_reg, asm_reg[i][BITS_PER_WORD-1:1]};
          end
          if (c_bits_reg == BW'(BITS_PER_WORD - 1)) begin
            c_bits_next = '0;
            state_next  = STOP;
          end else begin
            c_bits_next = c_bits_reg + 1'b1;
          end
        end else begin
          c_clocks_next = c_clocks_reg + 1'b1;
        end
      end
      STOP: begin
        if (bit_tick) begin
          c_clocks_next = '0;
          if (!rx_s_reg) begin
            frame_err_next = 1'b1;
            c_words_next   = '0;
            c_bits_next    = '0;
            asm_next       = '0;
            state_next     = RESYNC;
          end else if (c_bits_reg == BW'(END_BITS - 1)) begin
            c_bits_next = '0;
            if (c_words_reg == WW'(NUM_WORDS - 1)) begin
              state_next = DELIVER;
            end else begin
              c_words_next = c_words_reg + 1'b1;
              state_next   = IDLE;
            end
          end else begin
            c_bits_next = c_bits_reg + 1'b1;
          end
        end else begin
          c_clocks_next = c_clocks_reg + 1'b1;
        end
      end
      RESYNC: begin
        // Any low sample restarts the full idle bit-time requirement.
        if (!rx_s_reg) begin
          c_clocks_next = '0;
        end else if (bit_tick) begin
          c_clocks_next = '0;
          state_next    = IDLE;
        end else begin
          c_clocks_next = c_clocks_reg + 1'b1;
        end
      end
      DELIVER: begin
        if (!valid_reg || m_ready) begin
          out_next   = asm_reg;
          valid_next = 1'b1;
        end else begin
          overrun_next = 1'b1;
        end
        c_words_next = '0;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
